// File: rtl/pkt_mux_rr_pkg.sv
// ============================================================================
// Module      : pkt_mux_rr_pkg
// Description : Flit-type and FSM state encodings shared by the packet mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkt_mux_rr_pkg;

    typedef enum logic [1:0] {
        FT_NONE = 2'd0,
        FT_HEAD = 2'd1,
        FT_DATA = 2'd2,
        FT_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_mux_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotating-priority arbiter; grants the first
//               request at or after ptr, wrapping modulo NPORT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NPORT = 3,
    parameter int PTRW  = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [PTRW-1:0]  ptr,
    output logic [NPORT-1:0] gnt
);

    logic [2*NPORT-1:0] w_req_dbl;
    logic [2*NPORT-1:0] w_gnt_dbl;
    logic [NPORT-1:0]   w_rot;
    logic [NPORT-1:0]   w_rot_gnt;

    // Rotate so ptr lands at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        w_req_dbl = {req, req} >> ptr;
        w_rot     = w_req_dbl[NPORT-1:0];
        w_rot_gnt = w_rot & (~w_rot + NPORT'(1));
        w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << ptr;
        gnt       = w_gnt_dbl[2*NPORT-1:NPORT];
    end

endmodule

`default_nettype wire

// File: rtl/pkt_mux_rr.sv
// ============================================================================
// Module      : pkt_mux_rr
// Description : N-to-1 packet multiplexer with wormhole locking, round-robin
//               or static select, and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_mux_rr
    import pkt_mux_rr_pkg::*;
#(
    parameter int NPORT = 3,
    parameter int DATAW = 64,
    parameter int TYPEW = 2,
    parameter int VCHW  = 1,
    parameter int MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NPORT*(TYPEW+DATAW)-1:0]   idata,
    input  logic [NPORT-1:0]                 ivalid,
    input  logic [NPORT*VCHW-1:0]            ivch,
    output logic [NPORT-1:0]                 iready,
    input  logic [NPORT-1:0]                 sel,
    output logic [TYPEW+DATAW-1:0]           odata,
    output logic                             ovalid,
    output logic [VCHW-1:0]                  ovch,
    input  logic                             oready,
    output logic                             err_drop
);

    localparam int FLITW = TYPEW + DATAW;
    localparam int PTRW  = $clog2(NPORT);

    state_e            state_q, state_d;
    logic [PTRW-1:0]   gnt_q, gnt_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [FLITW-1:0]  odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic [VCHW-1:0]   ovch_q, ovch_d;
    logic              err_drop_q, err_drop_d;

    logic [FLITW-1:0]  w_flit [NPORT];
    logic [VCHW-1:0]   w_vch  [NPORT];
    logic [NPORT-1:0]  w_is_head;
    logic [NPORT-1:0]  w_is_tail;
    logic [NPORT-1:0]  w_is_orphan;
    logic [NPORT-1:0]  w_cand;
    logic [NPORT-1:0]  w_req;
    logic [PTRW-1:0]   w_ptr;
    logic [NPORT-1:0]  w_win;
    logic [NPORT-1:0]  w_ready;
    logic [NPORT-1:0]  w_xfer;
    logic              w_load;

    for (genvar k = 0; k < NPORT; k++) begin : g_port
        logic [TYPEW-1:0] w_type;
        assign w_flit[k]      = idata[k*FLITW +: FLITW];
        assign w_vch[k]       = ivch[k*VCHW +: VCHW];
        assign w_type         = w_flit[k][FLITW-1 -: TYPEW];
        assign w_is_head[k]   = (w_type == TYPEW'(FT_HEAD));
        assign w_is_tail[k]   = (w_type == TYPEW'(FT_TAIL));
        assign w_is_orphan[k] = (w_type == TYPEW'(FT_DATA)) || w_is_tail[k];
        assign w_cand[k]      = ivalid[k] && w_is_head[k];
    end

    // Static mode reuses the arbiter as a safe one-hot filter on sel.
    assign w_req  = (MODE == 0) ? w_cand : (w_cand & sel);
    assign w_ptr  = (MODE == 0) ? ptr_q  : '0;
    assign w_load = !ovalid_q || oready;

    rr_arbiter #(
        .NPORT (NPORT),
        .PTRW  (PTRW)
    ) u_arb (
        .req (w_req),
        .ptr (w_ptr),
        .gnt (w_win)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        odata_d    = odata_q;
        ovalid_d   = ovalid_q;
        ovch_d     = ovch_q;
        err_drop_d = 1'b0;
        w_ready    = '0;

        if (state_q == ST_IDLE) begin
            for (int k = 0; k < NPORT; k++) begin
                if (w_win[k] || (ivalid[k] && !w_is_head[k])) begin
                    w_ready[k] = w_load;
                end
            end
        end else begin
            w_ready[gnt_q] = w_load;
        end
        if (rst) begin
            w_ready = '0;
        end
        w_xfer = w_ready & ivalid;

        if (w_load) begin
            ovalid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            for (int k = 0; k < NPORT; k++) begin
                if (w_xfer[k] && w_win[k]) begin
                    odata_d  = w_flit[k];
                    ovch_d   = w_vch[k];
                    ovalid_d = 1'b1;
                    gnt_d    = PTRW'(k);
                    state_d  = ST_LOCKED;
                end else if (w_xfer[k] && w_is_orphan[k]) begin
                    err_drop_d = 1'b1;
                end
            end
        end else if (w_xfer[gnt_q]) begin
            odata_d  = w_flit[gnt_q];
            ovch_d   = w_vch[gnt_q];
            ovalid_d = 1'b1;
            if (w_is_tail[gnt_q]) begin
                state_d = ST_IDLE;
                if (MODE == 0) begin
                    ptr_d = (gnt_q == PTRW'(NPORT-1)) ? '0 : gnt_q + PTRW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            odata_q    <= '0;
            ovalid_q   <= 1'b0;
            ovch_q     <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            odata_q    <= odata_d;
            ovalid_q   <= ovalid_d;
            ovch_q     <= ovch_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign iready   = w_ready;
    assign odata    = odata_q;
    assign ovalid   = ovalid_q;
    assign ovch     = ovch_q;
    assign err_drop = err_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_mux_rr.sv
// ============================================================================
// Module      : tb_pkt_mux_rr
// Description : Directed self-checking bench for pkt_mux_rr (round-robin and
//               static-select instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_mux_rr;

    localparam int NP = 3;
    localparam int FW = 66;
    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_HEAD = 2'd1;
    localparam logic [1:0] T_DATA = 2'd2;
    localparam logic [1:0] T_TAIL = 2'd3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*FW-1:0] idata0, idata1;
    logic [NP-1:0]   ivalid0, ivalid1, ivch0, ivch1, sel0, sel1, iready0, iready1;
    logic [FW-1:0]   odata0, odata1;
    logic            ovalid0, ovalid1, oready0, oready1, err_drop0, err_drop1;
    logic [0:0]      ovch0, ovch1;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    logic [FW-1:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    pkt_mux_rr #(.NPORT(3), .DATAW(64), .TYPEW(2), .VCHW(1), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .idata(idata0), .ivalid(ivalid0), .ivch(ivch0),
        .iready(iready0), .sel(sel0), .odata(odata0), .ovalid(ovalid0),
        .ovch(ovch0), .oready(oready0), .err_drop(err_drop0)
    );

    pkt_mux_rr #(.NPORT(3), .DATAW(64), .TYPEW(2), .VCHW(1), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .idata(idata1), .ivalid(ivalid1), .ivch(ivch1),
        .iready(iready1), .sel(sel1), .odata(odata1), .ovalid(ovalid1),
        .ovch(ovch1), .oready(oready1), .err_drop(err_drop1)
    );

    function automatic logic [FW-1:0] mkf(input logic [1:0] t, input int p, input int s);
        return {t, 32'(p), 32'(s)};
    endfunction

    function automatic logic [1:0] ftyp(input int s, input int last);
        if (s == 0)    return T_HEAD;
        if (s == last) return T_TAIL;
        return T_DATA;
    endfunction

    function automatic logic vcof(input int p);
        return (p == 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic qpush(input int p, input logic [FW-1:0] f);
        case (p)
            0: q0.push_back(f);
            1: q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    task automatic present();
        idata0  = '0;
        ivalid0 = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        if (q0.size() != 0) idata0[0*FW +: FW] = q0[0];
        if (q1.size() != 0) idata0[1*FW +: FW] = q1[0];
        if (q2.size() != 0) idata0[2*FW +: FW] = q2[0];
    endtask

    // One cycle on dut0: present queue fronts, check iready, clock, check outputs.
    task automatic tick(input logic [2:0] er, input logic eov, input logic [FW-1:0] eod,
                        input logic evc, input logic eerr);
        logic [2:0] acc;
        step++;
        present();
        #1;
        chk("iready", 128'(iready0), 128'(er));
        acc = ivalid0 & iready0;
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
        chk("ovalid", 128'(ovalid0), 128'(eov));
        if (eov) begin
            chk("odata", 128'(odata0), 128'(eod));
            chk("ovch", 128'(ovch0), 128'(evc));
        end
        chk("err_drop", 128'(err_drop0), 128'(eerr));
    endtask

    initial begin
        rst = 1'b1;
        idata0 = '0; ivalid0 = '0; ivch0 = 3'b010; sel0 = '0; oready0 = 1'b1;
        idata1 = '0; ivalid1 = '0; ivch1 = 3'b010; sel1 = '0; oready1 = 1'b1;

        // Reset: outputs cleared and an incoming DATA flit is not accepted.
        qpush(2, mkf(T_DATA, 2, 9));
        tick(3'b000, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_odata", 128'(odata0), 128'd0);
        chk("rst_ovch", 128'(ovch0), 128'd0);
        chk("rst_ovalid1", 128'(ovalid1), 128'd0);
        q2.delete();
        rst = 1'b0;

        // Three simultaneous HEADs from ptr=0: served 0, 1, 2, each contiguous.
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 3; s++) qpush(p, mkf(ftyp(s, 2), p, s));
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 3; s++)
                tick(3'(1 << p), 1'b1, mkf(ftyp(s, 2), p, s), vcof(p), 1'b0);

        // Port 1: HEAD + 20 DATA + TAIL, one-cycle latency, ovch from port 1.
        for (int s = 0; s < 22; s++) qpush(1, mkf(ftyp(s, 21), 1, 100 + s));
        for (int s = 0; s < 22; s++) tick(3'b010, 1'b1, mkf(ftyp(s, 21), 1, 100 + s), 1'b1, 1'b0);

        // ptr now 2: port 2 beats port 0, then port 0 packet with a 5-cycle stall.
        for (int s = 0; s < 5; s++) qpush(0, mkf(ftyp(s, 4), 0, 200 + s));
        for (int s = 0; s < 2; s++) qpush(2, mkf(ftyp(s, 1), 2, 300 + s));
        tick(3'b100, 1'b1, mkf(T_HEAD, 2, 300), 1'b0, 1'b0);
        tick(3'b100, 1'b1, mkf(T_TAIL, 2, 301), 1'b0, 1'b0);
        tick(3'b001, 1'b1, mkf(T_HEAD, 0, 200), 1'b0, 1'b0);
        tick(3'b001, 1'b1, mkf(T_DATA, 0, 201), 1'b0, 1'b0);
        oready0 = 1'b0;
        for (int i = 0; i < 5; i++) tick(3'b000, 1'b1, mkf(T_DATA, 0, 201), 1'b0, 1'b0);
        oready0 = 1'b1;
        tick(3'b001, 1'b1, mkf(T_DATA, 0, 202), 1'b0, 1'b0);
        tick(3'b001, 1'b1, mkf(T_DATA, 0, 203), 1'b0, 1'b0);
        tick(3'b001, 1'b1, mkf(T_TAIL, 0, 204), 1'b0, 1'b0);

        // Orphans while IDLE: DATA pulses err_drop once, NONE is silent.
        tick(3'b000, 1'b0, '0, 1'b0, 1'b0);
        qpush(2, mkf(T_DATA, 2, 400));
        tick(3'b100, 1'b0, '0, 1'b0, 1'b1);
        tick(3'b000, 1'b0, '0, 1'b0, 1'b0);
        qpush(0, mkf(T_NONE, 0, 401));
        tick(3'b001, 1'b0, '0, 1'b0, 1'b0);
        // Winning HEAD on port 1 alongside an orphan DATA on port 2.
        qpush(1, mkf(T_HEAD, 1, 402));
        qpush(1, mkf(T_TAIL, 1, 403));
        qpush(2, mkf(T_DATA, 2, 404));
        tick(3'b110, 1'b1, mkf(T_HEAD, 1, 402), 1'b1, 1'b1);
        tick(3'b010, 1'b1, mkf(T_TAIL, 1, 403), 1'b1, 1'b0);

        // Reset after HEAD + 3 DATA: remaining flits become orphans, ptr back to 0.
        for (int s = 0; s < 6; s++) qpush(1, mkf(ftyp(s, 5), 1, 500 + s));
        for (int s = 0; s < 4; s++) tick(3'b010, 1'b1, mkf(ftyp(s, 5), 1, 500 + s), 1'b1, 1'b0);
        rst = 1'b1;
        tick(3'b000, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(3'b010, 1'b0, '0, 1'b0, 1'b1);
        tick(3'b010, 1'b0, '0, 1'b0, 1'b1);
        tick(3'b000, 1'b0, '0, 1'b0, 1'b0);
        qpush(0, mkf(T_HEAD, 0, 600));
        qpush(0, mkf(T_TAIL, 0, 601));
        qpush(2, mkf(T_HEAD, 2, 602));
        qpush(2, mkf(T_TAIL, 2, 603));
        tick(3'b001, 1'b1, mkf(T_HEAD, 0, 600), 1'b0, 1'b0);
        tick(3'b001, 1'b1, mkf(T_TAIL, 0, 601), 1'b0, 1'b0);
        tick(3'b100, 1'b1, mkf(T_HEAD, 2, 602), 1'b0, 1'b0);
        tick(3'b100, 1'b1, mkf(T_TAIL, 2, 603), 1'b0, 1'b0);

        // Static select instance: only the selected port is served.
        step = 1000;
        sel1 = 3'b010;
        ivalid1 = 3'b011;
        idata1[0*FW +: FW] = mkf(T_HEAD, 0, 700);
        idata1[1*FW +: FW] = mkf(T_HEAD, 1, 701);
        #1;
        chk("m1_iready", 128'(iready1), 128'(3'b010));
        @(posedge clk); #1;
        chk("m1_ovalid", 128'(ovalid1), 128'd1);
        chk("m1_odata", 128'(odata1), 128'(mkf(T_HEAD, 1, 701)));
        chk("m1_ovch", 128'(ovch1), 128'd1);
        step++;
        sel1 = 3'b001;
        idata1[1*FW +: FW] = mkf(T_TAIL, 1, 702);
        #1;
        chk("m1_iready", 128'(iready1), 128'(3'b010));
        @(posedge clk); #1;
        chk("m1_odata", 128'(odata1), 128'(mkf(T_TAIL, 1, 702)));
        step++;
        sel1 = 3'b010;
        ivalid1 = 3'b001;
        #1;
        chk("m1_iready", 128'(iready1), 128'(3'b000));
        @(posedge clk); #1;
        chk("m1_ovalid", 128'(ovalid1), 128'd0);
        step++;
        sel1 = 3'b001;
        #1;
        chk("m1_iready", 128'(iready1), 128'(3'b001));
        @(posedge clk); #1;
        chk("m1_ovalid", 128'(ovalid1), 128'd1);
        chk("m1_odata", 128'(odata1), 128'(mkf(T_HEAD, 0, 700)));
        chk("m1_ovch", 128'(ovch1), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
